// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; MTHI/MTLO write in one cycle. Optional macro: MD_UNIT_FLUSH_CANCEL_EN.
// Latency: result committed MULT_CYCLES/DIV_CYCLES edges after accept; MTHI/MTLO visible after one edge.
// Backpressure: md_busy stalls D-stage MD consumers; starts arriving while RUN are ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_busy
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        start_ok;

`ifdef MD_UNIT_FLUSH_CANCEL_EN
    assign start_ok = start & ~flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign start_ok     = start;
`endif

    assign md_busy = busy_q | (start_ok & ~op[2]);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;

    // One shared multiplier: operands sign- or zero-extended to 64 bits.
    logic [63:0] mul_a, mul_b, prod;
    assign mul_a = op[0] ? {32'd0, src_a} : {{32{src_a[31]}}, src_a};
    assign mul_b = op[0] ? {32'd0, src_b} : {{32{src_b[31]}}, src_b};
    assign prod  = mul_a * mul_b;

    // Signed divide runs on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
    logic        div_signed;
    logic [31:0] abs_a, abs_b, dvs, uq, ur, q, r;
    assign div_signed = ~op[0];
    assign abs_a = (div_signed & src_a[31]) ? -src_a : src_a;
    assign abs_b = (div_signed & src_b[31]) ? -src_b : src_b;
    assign dvs   = (src_b == 32'd0) ? 32'd1 : abs_b;
    assign uq    = abs_a / dvs;
    assign ur    = abs_a % dvs;
    assign q     = (div_signed & (src_a[31] ^ src_b[31])) ? -uq : uq;
    assign r     = (div_signed & src_a[31]) ? -ur : ur;

    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (op[1]) begin
            if (src_b == 32'd0) begin
                res_hi = src_a;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = r;
                res_lo = q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (!op[2]) begin
                        p_hi_d  = res_hi;
                        p_lo_d  = res_lo;
                        cnt_d   = op[1] ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
                        state_d = RUN;
                    end else if (op == 3'd4) begin
                        hi_d = src_a;
                    end else if (op == 3'd5) begin
                        lo_d = src_a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases with literal results plus randomized traffic against a behavioural model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, md_busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference results from plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic bit blocked(input logic fl);
`ifdef MD_UNIT_FLUSH_CANCEL_EN
        return fl;
`else
        return 1'b0 & fl;
`endif
    endfunction

    // Behavioural model: remaining busy cycles plus the pending {hi,lo}.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pend = 64'd0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (start && !blocked(flush)) begin
            if (op <= 3'd3) begin
                m_pend = ref_md(op, src_a, src_b);
                m_left = (op >= 3'd2) ? 10 : 5;
            end else if (op == 3'd4) begin
                m_hi = src_a;
            end else if (op == 3'd5) begin
                m_lo = src_a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("cyc_md_busy", {31'd0, md_busy},
                {31'd0, (m_left > 0) || (start && op <= 3'd3 && !blocked(flush))});
        end
    end

    // Called #1 after a rising edge; holds the request for exactly one edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl);
        start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_len(n);
        chk("mult_len", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_len(n);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_len(n);
        chk("div_len", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd0, 1'b0);
        run_len(n);
        chk("divu0_len", 32'(n), 32'd10);
        chk("divu0_hi", hi, 32'd7);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);

        issue(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, 32'hFFFF_FFFF);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("mthi_busy2", {31'd0, busy}, 32'd0);

        issue(3'd0, 32'd3, 32'd4, 1'b0);
        @(posedge clk); #1;
        issue(3'd5, 32'h0000_DEAD, 32'd0, 1'b0);
        run_len(n);
        chk("mtlo_run_lo", lo, 32'd12);
        chk("mtlo_run_hi", hi, 32'd0);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_len(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        issue(3'd3, 32'd100, 32'd7, 1'b0);
        run_len(n);
        chk("b2b_div_hi", hi, 32'd2);
        chk("b2b_div_lo", lo, 32'd14);
        issue(3'd1, 32'd4, 32'd5, 1'b0);
        run_len(n);
        chk("b2b_mul_len", 32'(n), 32'd5);
        chk("b2b_mul_hi", hi, 32'd0);
        chk("b2b_mul_lo", lo, 32'd20);

        start = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd3; flush = 1'b1;
        #1;
`ifdef MD_UNIT_FLUSH_CANCEL_EN
        chk("flush_md_busy", {31'd0, md_busy}, 32'd0);
`else
        chk("flush_md_busy", {31'd0, md_busy}, 32'd1);
`endif
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        run_len(n);
        repeat (2) @(posedge clk);
        #1;
`ifdef MD_UNIT_FLUSH_CANCEL_EN
        chk("flush_len", 32'(n), 32'd0);
        chk("flush_lo", lo, 32'd20);
`else
        chk("flush_len", 32'(n), 32'd5);
        chk("flush_lo", lo, 32'd6);
`endif

        issue(3'd0, 32'd9, 32'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstrun_hi", hi, 32'd0);
        chk("rstrun_lo", lo, 32'd0);
        chk("rstrun_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rstrun_late_lo", lo, 32'd0);
        chk("rstrun_late_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            src_a = pick();
            src_b = pick();
            flush = ($urandom_range(0, 5) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("final_busy", {31'd0, busy}, 32'd0);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
